// File: rtl/idma_tilelink_read_arbiter_if.sv
// Bundle of the requester-side Get/response signals and the TileLink-UL A/D channel signals.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface idma_tilelink_read_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned SizeWidth = 3,
  parameter int unsigned StrbWidth = 16
);
  localparam int unsigned DataWidth = 8 * StrbWidth;

  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*SizeWidth-1:0] req_size_i;
  logic                        a_valid_o;
  logic                        a_ready_i;
  logic [AddrWidth-1:0]        a_address_o;
  logic [SizeWidth-1:0]        a_size_o;
  logic                        d_valid_i;
  logic                        d_ready_o;
  logic [SizeWidth-1:0]        d_size_i;
  logic [DataWidth-1:0]        d_data_i;
  logic                        d_denied_i;
  logic                        d_corrupt_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [NumReq-1:0]           rsp_ready_i;
  logic [DataWidth-1:0]        rsp_data_o;
  logic                        rsp_last_o;
  logic                        rsp_err_o;
  logic                        busy_o;
  logic                        unexp_d_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_size_i, a_ready_i,
           d_valid_i, d_size_i, d_data_i, d_denied_i, d_corrupt_i, rsp_ready_i,
    output req_ready_o, a_valid_o, a_address_o, a_size_o, d_ready_o,
           rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o, busy_o, unexp_d_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_size_i, a_ready_i,
           d_valid_i, d_size_i, d_data_i, d_denied_i, d_corrupt_i, rsp_ready_i,
    input  req_ready_o, a_valid_o, a_address_o, a_size_o, d_ready_o,
           rsp_valid_o, rsp_data_o, rsp_last_o, rsp_err_o, busy_o, unexp_d_o
  );
endinterface

// File: rtl/idma_tilelink_read_arbiter.sv
// Shares one TileLink-UL Get port between NumReq read requesters: round-robin A arbitration
// with grant locking, and an in-order ID FIFO that steers D beats back to the issuing requester.
module idma_tilelink_read_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned SizeWidth      = 3,
  parameter int unsigned StrbWidth      = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                          clk_i,
  input logic                          rst_i,
  idma_tilelink_read_arbiter_if.slave  bus
);
  localparam int unsigned DataWidth = 8 * StrbWidth;
  localparam int unsigned IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned StrbLog   = $clog2(StrbWidth);
  localparam int          MaxExp    = (2 ** SizeWidth) - 1 - int'(StrbLog);
  localparam int unsigned CntW      = (MaxExp > 0) ? MaxExp + 1 : 1;

  localparam logic [SizeWidth-1:0] StrbLogS = SizeWidth'(StrbLog);
  localparam logic [PtrW:0]        FifoMax  = (PtrW + 1)'(MaxOutstanding);
  localparam logic [PtrW-1:0]      PtrLast  = PtrW'(MaxOutstanding - 1);
  localparam logic [IdxW-1:0]      IdxLast  = IdxW'(NumReq - 1);

  logic [IdxW-1:0] r_rr_ptr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic [CntW-1:0] r_beat_cnt;
  logic            r_unexp;

  logic [IdxW-1:0]   w_rr_idx;
  logic [IdxW-1:0]   w_grant;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_a_valid;
  logic              w_a_hs;
  logic [IdxW-1:0]   w_owner;
  logic              w_d_route;
  logic              w_d_ready;
  logic              w_d_hs;
  logic [CntW-1:0]   w_beats;
  logic              w_last;
  logic              w_pop;
  logic [NumReq-1:0] w_req_ready;
  logic [NumReq-1:0] w_rsp_valid;

  // Scan from the farthest offset down so the nearest valid requester at/after the pointer wins.
  always_comb begin
    w_rr_idx = r_rr_ptr;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      if (bus.req_valid_i[(int'(r_rr_ptr) + k) % int'(NumReq)]) begin
        w_rr_idx = IdxW'((int'(r_rr_ptr) + k) % int'(NumReq));
      end
    end
  end

  assign w_grant      = r_lock ? r_lock_idx : w_rr_idx;
  assign w_fifo_full  = (r_count == FifoMax);
  assign w_fifo_empty = (r_count == '0);
  assign w_a_valid    = (|bus.req_valid_i) & ~w_fifo_full;
  assign w_a_hs       = w_a_valid & bus.a_ready_i;

  assign w_owner   = r_fifo[r_rd_ptr];
  assign w_d_route = bus.d_valid_i & ~w_fifo_empty;
  assign w_d_ready = bus.rsp_ready_i[w_owner] & ~w_fifo_empty;
  assign w_d_hs    = bus.d_valid_i & w_d_ready;

  always_comb begin
    if (bus.d_size_i <= StrbLogS) begin
      w_beats = CntW'(1);
    end else begin
      w_beats = CntW'(1) << (bus.d_size_i - StrbLogS);
    end
  end

  assign w_last = ((r_beat_cnt == '0) && (w_beats == CntW'(1))) || (r_beat_cnt == CntW'(1));
  assign w_pop  = w_d_hs & w_last;

  always_comb begin
    w_req_ready = '0;
    w_rsp_valid = '0;
    if (w_a_hs) w_req_ready[w_grant] = 1'b1;
    if (w_d_route) w_rsp_valid[w_owner] = 1'b1;
  end

  // Everything is forced low while reset is held, including the purely combinational paths.
  assign bus.req_ready_o = rst_i ? '0 : w_req_ready;
  assign bus.a_valid_o   = w_a_valid & ~rst_i;
  assign bus.a_address_o = rst_i ? '0 : bus.req_addr_i[w_grant*AddrWidth +: AddrWidth];
  assign bus.a_size_o    = rst_i ? '0 : bus.req_size_i[w_grant*SizeWidth +: SizeWidth];
  assign bus.d_ready_o   = w_d_ready & ~rst_i;
  assign bus.rsp_valid_o = rst_i ? '0 : w_rsp_valid;
  assign bus.rsp_data_o  = rst_i ? DataWidth'(0) : bus.d_data_i;
  assign bus.rsp_last_o  = w_d_route & w_last & ~rst_i;
  assign bus.rsp_err_o   = w_d_route & (bus.d_denied_i | bus.d_corrupt_i) & ~rst_i;
  assign bus.busy_o      = (~w_fifo_empty | w_a_valid) & ~rst_i;
  assign bus.unexp_d_o   = r_unexp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
      r_unexp    <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) r_fifo[i] <= '0;
    end else begin
      if (w_a_hs) begin
        r_fifo[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
        r_rr_ptr         <= (w_grant == IdxLast) ? '0 : w_grant + IdxW'(1);
        r_lock           <= 1'b0;
      end else if (w_a_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant;
      end

      if (w_d_hs) begin
        if (r_beat_cnt == '0) r_beat_cnt <= w_beats - CntW'(1);
        else                  r_beat_cnt <= r_beat_cnt - CntW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrW'(1);
      end

      if (w_a_hs && !w_pop)      r_count <= r_count + (PtrW + 1)'(1);
      else if (!w_a_hs && w_pop) r_count <= r_count - (PtrW + 1)'(1);

      if (bus.d_valid_i && w_fifo_empty) r_unexp <= 1'b1;
    end
  end
endmodule
